// File: rtl/sram_1rw1r_arbiter.sv
// sram_1rw1r_arbiter: round-robin A/B arbiter on the 1RW port and C reader on the R port of a 512x32 SRAM.
module sram_1rw1r_arbiter #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [NUM_WMASKS-1:0] a_wstrb,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [NUM_WMASKS-1:0] b_wstrb,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic [DATA_WIDTH-1:0] b_rdata,
    input  logic                  c_valid,
    output logic                  c_ready,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    output logic [DATA_WIDTH-1:0] c_rdata,
    output logic                  clk0,
    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0,
    output logic                  clk1,
    output logic                  csb1,
    output logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] dout1
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t s0, s0_n, s1, s1_n;
    logic last_b, gnt_b, gnt_b_q, wr0_q, go0, go1, w0;
    logic [NUM_WMASKS-1:0] st0;
    logic [ADDR_WIDTH-1:0] ad0;
    logic [DATA_WIDTH-1:0] wd0;

    assign clk0 = clk;
    assign clk1 = clk;

    always_comb begin
        gnt_b = b_valid && (!a_valid || !last_b);
        st0   = gnt_b ? b_wstrb : a_wstrb;
        ad0   = gnt_b ? b_addr : a_addr;
        wd0   = gnt_b ? b_wdata : a_wdata;
        w0    = st0 != '0;
        go0   = (s0 == IDLE) && (a_valid || b_valid);
        // C holds off one cycle so its read lands after a same-address write
        go1   = (s1 == IDLE) && c_valid && !(go0 && w0 && c_addr == ad0);
        s0_n  = go0 ? ISSUE : s0 == ISSUE ? WAIT : s0 == WAIT ? RESP : IDLE;
        s1_n  = go1 ? ISSUE : s1 == ISSUE ? WAIT : s1 == WAIT ? RESP : IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s0      <= IDLE;
            last_b  <= 1'b1;
            gnt_b_q <= 1'b0;
            wr0_q   <= 1'b0;
            csb0    <= 1'b1;
            web0    <= 1'b1;
            wmask0  <= '0;
            addr0   <= '0;
            din0    <= '0;
            a_ready <= 1'b0;
            b_ready <= 1'b0;
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            s0      <= s0_n;
            csb0    <= !go0;
            web0    <= !(go0 && w0);
            wmask0  <= go0 ? st0 : '0;
            a_ready <= s0 == WAIT && !gnt_b_q;
            b_ready <= s0 == WAIT && gnt_b_q;
            if (go0) begin
                last_b  <= gnt_b;
                gnt_b_q <= gnt_b;
                wr0_q   <= w0;
                addr0   <= ad0;
                din0    <= w0 ? wd0 : '0;
            end
            if (s0 == WAIT && !wr0_q && gnt_b_q) b_rdata <= dout0;
            if (s0 == WAIT && !wr0_q && !gnt_b_q) a_rdata <= dout0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1      <= IDLE;
            csb1    <= 1'b1;
            addr1   <= '0;
            c_ready <= 1'b0;
            c_rdata <= '0;
        end else begin
            s1      <= s1_n;
            csb1    <= !go1;
            c_ready <= s1 == WAIT;
            if (go1) addr1 <= c_addr;
            if (s1 == WAIT) c_rdata <= dout1;
        end
    end
endmodule

// File: tb/tb_sram_1rw1r_arbiter.sv
// tb_sram_1rw1r_arbiter: randomized scoreboard bench with an SRAM model and a word-level reference memory.
module tb_sram_1rw1r_arbiter;
    logic clk = 1'b0, resetn = 1'b0;
    logic a_valid = 1'b0, b_valid = 1'b0, c_valid = 1'b0;
    logic [8:0] a_addr = '0, b_addr = '0, c_addr = '0;
    logic [3:0] a_wstrb = '0, b_wstrb = '0;
    logic [31:0] a_wdata = '0, b_wdata = '0;
    logic a_ready, b_ready, c_ready, clk0, clk1, csb0, csb1, web0;
    logic [31:0] a_rdata, b_rdata, c_rdata, din0, dout0, dout1;
    logic [3:0] wmask0;
    logic [8:0] addr0, addr1;
    logic [31:0] sram [512];
    logic [31:0] ref_mem [512];
    logic [31:0] qa [$], qb [$], qc [$];
    logic [31:0] last [3];
    logic first = 1'b1;
    int checks = 0, errors = 0;

    sram_1rw1r_arbiter #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .NUM_WMASKS(4)) dut (
        .clk(clk), .resetn(resetn),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_wstrb(a_wstrb), .a_wdata(a_wdata), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_wstrb(b_wstrb), .b_wdata(b_wdata), .b_rdata(b_rdata),
        .c_valid(c_valid), .c_ready(c_ready), .c_addr(c_addr), .c_rdata(c_rdata),
        .clk0(clk0), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0), .dout0(dout0),
        .clk1(clk1), .csb1(csb1), .addr1(addr1), .dout1(dout1)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] seed(input int i);
        return 32'(i) * 32'h9E3779B1 ^ 32'h5A5A0000;
    endfunction

    // Macro model: command captured at the clock edge, read data available one cycle later
    always @(posedge clk) begin
        logic [31:0] w;
        if (first) begin
            for (int i = 0; i < 512; i++) sram[i] <= seed(i);
            first <= 1'b0;
        end else begin
            if (!csb0) begin
                if (!web0) begin
                    w = sram[addr0];
                    for (int i = 0; i < 4; i++) if (wmask0[i]) w[8*i +: 8] = din0[8*i +: 8];
                    sram[addr0] <= w;
                end else dout0 <= sram[addr0];
            end
            if (!csb1) dout1 <= sram[addr1];
        end
    end

    task automatic expect_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic ref_write(input logic [8:0] ad, input logic [31:0] wd, input logic [3:0] st);
        for (int i = 0; i < 4; i++) if (st[i]) ref_mem[ad][8*i +: 8] = wd[8*i +: 8];
    endtask

    task automatic flush();
        qa.delete(); qb.delete(); qc.delete();
        for (int i = 0; i < 3; i++) last[i] = '0;
    endtask

    function automatic logic rdy(input int r);
        return r == 0 ? a_ready : r == 1 ? b_ready : c_ready;
    endfunction

    task automatic issue(input int r, input logic [8:0] ad, input logic [3:0] st, input logic [31:0] wd);
        logic [31:0] e;
        if (st == 0) e = ref_mem[ad];
        else begin
            ref_write(ad, wd, st);
            e = last[r];
        end
        last[r] = e;
        if (r == 0) begin
            qa.push_back(e); a_valid = 1'b1; a_addr = ad; a_wstrb = st; a_wdata = wd;
        end else if (r == 1) begin
            qb.push_back(e); b_valid = 1'b1; b_addr = ad; b_wstrb = st; b_wdata = wd;
        end else begin
            qc.push_back(e); c_valid = 1'b1; c_addr = ad;
        end
    endtask

    task automatic drop(input int r);
        if (r == 0) a_valid = 1'b0;
        else if (r == 1) b_valid = 1'b0;
        else c_valid = 1'b0;
    endtask

    task automatic wait_rdy(input int r, output int cnt);
        cnt = 0;
        do begin
            @(posedge clk); #1; cnt++;
        end while (!rdy(r) && cnt < 40);
        if (!rdy(r)) begin
            checks++; errors++;
            $display("FAIL timeout_%0d: got no ready in %0d cycles, required a ready", r, cnt);
        end
    endtask

    task automatic req(input int r, input logic [8:0] ad, input logic [3:0] st, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd);
        int n;
        @(negedge clk);
        issue(r, ad, st, wd);
        wait_rdy(r, n);
        lat = n - 1;
        rd = r == 0 ? a_rdata : r == 1 ? b_rdata : c_rdata;
        drop(r);
        @(posedge clk);
    endtask

    task automatic mon(input int r, input logic [31:0] act);
        logic [31:0] e;
        bit have;
        have = r == 0 ? qa.size() > 0 : r == 1 ? qb.size() > 0 : qc.size() > 0;
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL unexpected_ready_%0d: got ready with rdata %h, required no ready", r, act);
        end else begin
            if (r == 0) e = qa.pop_front();
            else if (r == 1) e = qb.pop_front();
            else e = qc.pop_front();
            if (act !== e) begin
                errors++;
                $display("FAIL rdata_%0d: got %h, required %h", r, act, e);
            end
        end
    endtask

    initial forever begin
        @(posedge clk); #1;
        if (a_ready) mon(0, a_rdata);
        if (b_ready) mon(1, b_rdata);
        if (c_ready) mon(2, c_rdata);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

    initial begin
        int lat, lc, pulses, n, cyc;
        int who [4], t [4];
        logic [31:0] rd, rc;
        for (int i = 0; i < 512; i++) ref_mem[i] = seed(i);
        flush();
        repeat (3) @(posedge clk);
        #1;
        expect_eq("rst_csb0", 32'(csb0), 1);
        expect_eq("rst_csb1", 32'(csb1), 1);
        expect_eq("rst_web0", 32'(web0), 1);
        expect_eq("rst_wmask0", 32'(wmask0), 0);
        expect_eq("rst_addr0", 32'(addr0), 0);
        expect_eq("rst_din0", din0, 0);
        expect_eq("rst_readies", {29'b0, a_ready, b_ready, c_ready}, 0);
        expect_eq("rst_a_rdata", a_rdata, 0);
        expect_eq("rst_b_rdata", b_rdata, 0);
        expect_eq("rst_c_rdata", c_rdata, 0);
        expect_eq("clk_wires", {30'b0, clk0, clk1}, {30'b0, clk, clk});
        @(negedge clk) resetn = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (!csb0 || !csb1) pulses++;
        end
        expect_eq("idle_no_csb_pulse", pulses, 0);

        req(0, 5, 4'hF, 32'hDEADBEEF, lat, rd);
        expect_eq("a_write_latency", lat, 2);
        req(0, 5, 4'h0, 0, lat, rd);
        expect_eq("a_read_latency", lat, 2);
        expect_eq("a_read_data", rd, 32'hDEADBEEF);

        req(0, 7, 4'hF, 32'h11223344, lat, rd);
        req(1, 7, 4'b0101, 32'hAABBCCDD, lat, rd);
        expect_eq("b_write_latency", lat, 2);
        req(0, 7, 4'h0, 0, lat, rd);
        expect_eq("partial_write_data", rd, 32'h11BB33DD);

        req(2, 300, 4'h0, 0, lc, rc);
        expect_eq("c_nominal_latency", lc, 2);
        ref_write(9, 32'h0000CAFE, 4'hF);
        fork
            req(0, 9, 4'hF, 32'h0000CAFE, lat, rd);
            req(2, 9, 4'h0, 0, lc, rc);
        join
        expect_eq("collision_a_latency", lat, 2);
        expect_eq("collision_c_latency", lc, 3);
        expect_eq("collision_c_data", rc, 32'h0000CAFE);
        fork
            req(0, 10, 4'hF, 32'h01234567, lat, rd);
            req(2, 11, 4'h0, 0, lc, rc);
        join
        expect_eq("diff_addr_c_latency", lc, 2);
        fork
            req(0, 9, 4'h0, 0, lat, rd);
            req(2, 9, 4'h0, 0, lc, rc);
        join
        expect_eq("shared_read_c_latency", lc, 2);

        @(negedge clk) resetn = 1'b0;
        flush();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        issue(0, 30, 4'h0, 0); issue(0, 30, 4'h0, 0);
        issue(1, 140, 4'h0, 0); issue(1, 140, 4'h0, 0);
        for (int i = 0; i < 4; i++) begin
            who[i] = -1; t[i] = -1;
        end
        n = 0; cyc = 0;
        while (n < 4 && cyc < 40) begin
            @(posedge clk); #1; cyc++;
            if (a_ready && n < 4) begin who[n] = 0; t[n] = cyc; n++; end
            if (b_ready && n < 4) begin who[n] = 1; t[n] = cyc; n++; end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk);
        expect_eq("contention_count", n, 4);
        for (int i = 0; i < 4; i++) begin
            expect_eq($sformatf("contention_grant_%0d", i), who[i], i % 2);
            expect_eq($sformatf("contention_time_%0d", i), t[i], 3 + 4 * i);
        end

        @(negedge clk);
        a_valid = 1'b1; a_addr = 20; a_wstrb = 0;
        @(posedge clk); #1;
        expect_eq("issue_csb0_low", 32'(csb0), 0);
        resetn = 1'b0;
        flush();
        #1;
        expect_eq("async_reset_csb0", 32'(csb0), 1);
        a_valid = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        @(negedge clk);
        a_valid = 1'b1; a_addr = 21; a_wstrb = 0;
        @(posedge clk);
        @(posedge clk); #1;
        resetn = 1'b0;
        flush();
        #1;
        expect_eq("wait_reset_csb0", 32'(csb0), 1);
        expect_eq("wait_reset_a_ready", 32'(a_ready), 0);
        expect_eq("wait_reset_a_rdata", a_rdata, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        issue(0, 21, 4'h0, 0);
        wait_rdy(0, n);
        expect_eq("regrant_latency", n, 3);
        a_valid = 1'b0;
        @(posedge clk);

        fork
            for (int k = 0; k < 15; k++) begin
                int la; logic [31:0] ra; logic [3:0] st;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                st = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0;
                req(0, 9'($urandom_range(16, 127)), st, $urandom, la, ra);
            end
            for (int k = 0; k < 15; k++) begin
                int lb; logic [31:0] rb; logic [3:0] st;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                st = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0;
                req(1, 9'($urandom_range(128, 255)), st, $urandom, lb, rb);
            end
            for (int k = 0; k < 15; k++) begin
                int lq; logic [31:0] rq;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                req(2, 9'($urandom_range(256, 511)), 4'h0, 0, lq, rq);
            end
        join
        repeat (10) @(posedge clk);
        expect_eq("drain_queues", qa.size() + qb.size() + qc.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
